// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults, selector-width helper and error-cause codes for the register file.
package rf_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREGS = 8;
    localparam int ERR_DOUBLE_RESV = 0;
    localparam int ERR_RANGE = 1;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rf_dffe_n.sv
// rf_dffe_n: W-bit enabled flop with asynchronous active-low reset to zero.
module rf_dffe_n
    import rf_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_o <= '0;
        else if (en_i) q_o <= d_i;
endmodule

// File: rtl/rf_scoreboard_bypass.sv
// rf_scoreboard_bypass: parametrised register file with write-to-read bypass,
// a per-register busy scoreboard for RAW detection, and a sticky error flag.
module rf_scoreboard_bypass
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int SEL_W  = sel_w(NREGS),
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  read1regsel,
    input  logic [SEL_W-1:0]  read2regsel,
    output logic [DATA_W-1:0] read1data,
    output logic [DATA_W-1:0] read2data,
    output logic              read1busy,
    output logic              read2busy,
    input  logic [SEL_W-1:0]  writeregsel,
    input  logic [DATA_W-1:0] writedata,
    input  logic              write,
    input  logic [SEL_W-1:0]  resvregsel,
    input  logic              resv,
    input  logic              flush,
    output logic              err
);
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d, wr_hot, rv_hot;
    logic              wr_ok, rv_ok, dbl, rng, err_q;
    logic [SEL_W-1:0]  rsel [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    assign wr_ok  = write && 32'(writeregsel) < NREGS;
    assign rv_ok  = resv && 32'(resvregsel) < NREGS;
    assign wr_hot = wr_ok ? NREGS'(1) << writeregsel : '0;
    assign rv_hot = rv_ok ? NREGS'(1) << resvregsel : '0;
    // a reserve landing on the write target wins: the new producer is still pending
    assign busy_d = flush ? '0 : (busy_q & ~wr_hot) | rv_hot;
    assign dbl    = !flush && |(rv_hot & busy_q & ~wr_hot);
    assign rng    = 32'(read1regsel) >= NREGS || 32'(read2regsel) >= NREGS ||
                    32'(writeregsel) >= NREGS || 32'(resvregsel) >= NREGS;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        rf_dffe_n #(.W(DATA_W)) u_reg (
            .clk(clk), .rst_n(rst), .en_i(wr_hot[i]), .d_i(writedata), .q_o(regs_q[i])
        );
    end

    rf_dffe_n #(.W(NREGS)) u_busy (
        .clk(clk), .rst_n(rst), .en_i(1'b1), .d_i(busy_d), .q_o(busy_q)
    );

    rf_dffe_n #(.W(1)) u_err (
        .clk(clk), .rst_n(rst), .en_i(dbl | rng), .d_i(1'b1), .q_o(err_q)
    );

    assign err     = err_q;
    assign rsel[0] = read1regsel;
    assign rsel[1] = read2regsel;

    // outputs are forced low during reset so bypassed write data cannot leak through
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic in_rng, hit;
        assign in_rng   = 32'(rsel[p]) < NREGS;
        assign hit      = BYPASS != 0 && wr_ok && writeregsel == rsel[p];
        assign rdata[p] = (!rst || !in_rng) ? '0 : hit ? writedata : regs_q[rsel[p]];
        assign rbusy[p] = rst && in_rng && (hit ? rv_ok && resvregsel == rsel[p] : busy_q[rsel[p]]);
    end

    assign read1data = rdata[0];
    assign read2data = rdata[1];
    assign read1busy = rbusy[0];
    assign read2busy = rbusy[1];
endmodule

// File: tb/tb_rf_scoreboard_bypass.sv
// tb_rf_scoreboard_bypass: three configurations (8/bypass, 8/no bypass, 6/bypass) on shared
// stimulus, checked against an array-based reference model.
module tb_rf_scoreboard_bypass;
    import rf_pkg::*;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, wr, rv, fl;
    logic [2:0]    r1s, r2s, ws, rs;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd1 [3], rd2 [3];
    logic          rb1 [3], rb2 [3], er [3];

    logic [DW-1:0] m_reg [3][8];
    logic          m_bsy [3][8];
    logic          m_err [3];
    int            n_checks = 0, n_errors = 0;

    rf_scoreboard_bypass #(.DATA_W(DW), .NREGS(8), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
        .read1data(rd1[0]), .read2data(rd2[0]), .read1busy(rb1[0]), .read2busy(rb2[0]),
        .writeregsel(ws), .writedata(wd), .write(wr), .resvregsel(rs), .resv(rv),
        .flush(fl), .err(er[0])
    );
    rf_scoreboard_bypass #(.DATA_W(DW), .NREGS(8), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
        .read1data(rd1[1]), .read2data(rd2[1]), .read1busy(rb1[1]), .read2busy(rb2[1]),
        .writeregsel(ws), .writedata(wd), .write(wr), .resvregsel(rs), .resv(rv),
        .flush(fl), .err(er[1])
    );
    rf_scoreboard_bypass #(.DATA_W(DW), .NREGS(6), .BYPASS(1)) u_six (
        .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s),
        .read1data(rd1[2]), .read2data(rd2[2]), .read1busy(rb1[2]), .read2busy(rb2[2]),
        .writeregsel(ws), .writedata(wd), .write(wr), .resvregsel(rs), .resv(rv),
        .flush(fl), .err(er[2])
    );

    function automatic int nr(int k);
        return k == 2 ? 6 : 8;
    endfunction

    function automatic bit bp(int k);
        return k != 1;
    endfunction

    function automatic logic [DW-1:0] exp_data(int k, int s);
        if (!rst || s >= nr(k)) return '0;
        if (bp(k) && wr && int'(ws) == s) return wd;
        return m_reg[k][s];
    endfunction

    function automatic logic exp_busy(int k, int s);
        if (!rst || s >= nr(k)) return 1'b0;
        if (bp(k) && wr && int'(ws) == s) return rv && int'(rs) == s;
        return m_bsy[k][s];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_err[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_reg[k][i] = '0;
                m_bsy[k][i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int n = nr(k);
            bit wv = wr && int'(ws) < n;
            bit vv = rv && int'(rs) < n;
            if (int'(r1s) >= n || int'(r2s) >= n || int'(ws) >= n || int'(rs) >= n) m_err[k] = 1'b1;
            if (vv && !fl && m_bsy[k][rs] && !(wv && ws == rs)) m_err[k] = 1'b1;
            if (wv) begin
                m_reg[k][ws] = wd;
                m_bsy[k][ws] = 1'b0;
            end
            if (vv) m_bsy[k][rs] = 1'b1;
            if (fl) for (int i = 0; i < 8; i++) m_bsy[k][i] = 1'b0;
        end
    endtask

    task automatic settle();
        #1;
        if (!rst) model_clear();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("u%0d rd1 sel%0d", k, r1s), rd1[k], exp_data(k, r1s));
            check($sformatf("u%0d rd2 sel%0d", k, r2s), rd2[k], exp_data(k, r2s));
            check($sformatf("u%0d busy1 sel%0d", k, r1s), rb1[k], exp_busy(k, r1s));
            check($sformatf("u%0d busy2 sel%0d", k, r2s), rb2[k], exp_busy(k, r2s));
            check($sformatf("u%0d err", k), er[k], m_err[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle();
        {wr, rv, fl} = '0;
        {r1s, r2s, ws, rs} = '0;
        wd = '0;
    endtask

    task automatic rand_in();
        r1s = 3'($urandom_range(0, 7));
        r2s = 3'($urandom_range(0, 7));
        ws  = 3'($urandom_range(0, 7));
        rs  = 3'($urandom_range(0, 7));
        wd  = DW'($urandom);
        wr  = 1'($urandom_range(0, 1));
        rv  = $urandom_range(0, 3) == 0;
        fl  = $urandom_range(0, 15) == 0;
    endtask

    initial begin
        rst = 1'b0;
        model_clear();
        idle();
        @(negedge clk);
        settle();
        check("reset rd1", rd1[0], 0);
        check("reset busy1", rb1[0], 0);
        tick();
        rst = 1'b1;
        repeat (20) begin
            rand_in();
            cyc();
        end
        // asynchronous reset in the middle of traffic, checked before any clock edge
        rst = 1'b0;
        rand_in();
        wr = 1'b1;
        ws = r1s;
        settle();
        check("mid reset rd1", rd1[0], 0);
        check("mid reset rd2", rd2[0], 0);
        check("mid reset busy1", rb1[0], 0);
        check("mid reset err", er[0], 0);
        tick();
        rst = 1'b1;
        idle();
        settle();
        check("post reset rd1", rd1[0], 0);
        check("post reset err", er[0], 0);
        tick();

        idle();
        wr = 1'b1; ws = 3'd3; wd = 16'hBEEF; r2s = 3'd3;
        settle();
        check("bypass rd2", rd2[0], 16'hBEEF);
        check("no bypass rd2", rd2[1], 16'h0000);
        tick();
        idle();
        r1s = 3'd3;
        settle();
        check("stored rd1", rd1[0], 16'hBEEF);
        check("stored rd1 no bypass", rd1[1], 16'hBEEF);
        tick();

        idle();
        rv = 1'b1; rs = 3'd5;
        cyc();
        idle();
        r1s = 3'd5;
        settle();
        check("resv busy5", rb1[0], 1);
        tick();
        idle();
        wr = 1'b1; ws = 3'd5; wd = 16'h1234; r1s = 3'd5;
        settle();
        check("wb busy5", rb1[0], 0);
        check("wb data5", rd1[0], 16'h1234);
        check("wb busy5 no bypass", rb1[1], 1);
        tick();
        idle();
        r1s = 3'd5;
        settle();
        check("after wb busy5", rb1[0], 0);
        tick();

        idle();
        rv = 1'b1; rs = 3'd2; wr = 1'b1; ws = 3'd2; wd = 16'h00AA;
        cyc();
        idle();
        r1s = 3'd2;
        settle();
        check("resv+wr data2", rd1[0], 16'h00AA);
        check("resv+wr busy2", rb1[0], 1);
        tick();

        foreach (rd1[j]) begin
            idle();
            rv = 1'b1;
            rs = (j == 0) ? 3'd1 : (j == 1) ? 3'd4 : 3'd6;
            cyc();
        end
        idle();
        fl = 1'b1; rv = 1'b1; rs = 3'd7;
        cyc();
        for (int s = 0; s < 8; s++) begin
            idle();
            r1s = 3'(s);
            settle();
            check($sformatf("flush busy%0d", s), rb1[0], 0);
            tick();
        end

        rst = 1'b0;
        idle();
        cyc();
        rst = 1'b1;
        rv = 1'b1; rs = 3'd0;
        cyc();
        settle();
        check($sformatf("cause %0d first resv", ERR_DOUBLE_RESV), er[0], 0);
        tick();
        idle();
        settle();
        check($sformatf("cause %0d double resv", ERR_DOUBLE_RESV), er[0], 1);
        tick();
        repeat (3) cyc();
        settle();
        check("double resv held", er[0], 1);
        rst = 1'b0;
        settle();
        check("err cleared by reset", er[0], 0);
        tick();
        rst = 1'b1;

        idle();
        wr = 1'b1; ws = 3'd7; wd = 16'hFFFF;
        cyc();
        idle();
        settle();
        check($sformatf("cause %0d six regs", ERR_RANGE), er[2], 1);
        check($sformatf("cause %0d eight regs", ERR_RANGE), er[0], 0);
        tick();
        for (int s = 0; s < 6; s++) begin
            idle();
            r1s = 3'(s);
            settle();
            check($sformatf("six regs untouched %0d", s), rd1[2], 0);
            tick();
        end

        repeat (3) begin
            rst = 1'b0;
            idle();
            cyc();
            rst = 1'b1;
            repeat (300) begin
                rand_in();
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
